// File: rtl/ctrl_pkg.sv
// Shared definitions for the control path: instruction opcode encoding (also used by ctrl_unit
// and software tools), fetch/decode FSM states and register-select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    OpHalt        = 4'h0,
    OpLoadRdn     = 4'h1,
    OpLoadDnn     = 4'h2,
    OpProc        = 4'h3,
    OpSetImgAddr  = 4'h4,
    OpSetImgCnt   = 4'h5,
    OpSetRsltAddr = 4'h6,
    OpNop         = 4'h7
  } instr_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWaitCtrl,
    StHalted,
    StError
  } ifd_state_t;

  localparam logic [1:0] REG_SEL_IMG_ADDR  = 2'b00;
  localparam logic [1:0] REG_SEL_IMG_CNT   = 2'b01;
  localparam logic [1:0] REG_SEL_RSLT_ADDR = 2'b10;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder.
//   opcode     : instruction bits [31:28]
//   issue      : high in the ISSUE cycle; gates strobes and reg_sel
//   begin_*    : command strobes, reg_wr_en : register write strobe, reg_sel : target register
//   is_cmd / is_halt / is_illegal : classification flags (ungated)
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       issue,
  output logic       begin_rdn_load,
  output logic       begin_dnn_load,
  output logic       begin_proc,
  output logic       reg_wr_en,
  output logic [1:0] reg_sel,
  output logic       is_cmd,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    begin_rdn_load = 1'b0;
    begin_dnn_load = 1'b0;
    begin_proc     = 1'b0;
    reg_wr_en      = 1'b0;
    reg_sel        = REG_SEL_IMG_ADDR;
    is_cmd         = 1'b0;
    is_halt        = 1'b0;
    is_illegal     = 1'b0;
    case (opcode)
      OpHalt:    is_halt = 1'b1;
      OpLoadRdn: begin
        is_cmd         = 1'b1;
        begin_rdn_load = issue;
      end
      OpLoadDnn: begin
        is_cmd         = 1'b1;
        begin_dnn_load = issue;
      end
      OpProc: begin
        is_cmd     = 1'b1;
        begin_proc = issue;
      end
      OpSetImgAddr: begin
        reg_wr_en = issue;
        reg_sel   = REG_SEL_IMG_ADDR;
      end
      OpSetImgCnt: begin
        reg_wr_en = issue;
        reg_sel   = issue ? REG_SEL_IMG_CNT : REG_SEL_IMG_ADDR;
      end
      OpSetRsltAddr: begin
        reg_wr_en = issue;
        reg_sel   = issue ? REG_SEL_RSLT_ADDR : REG_SEL_IMG_ADDR;
      end
      OpNop:   ;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode stage feeding ctrl_unit. Walks the program image from pc 0 after
// instrVld, issuing register writes and command strobes; commands stall until incPc.
//   clk, rst_n         : clock, async active-low reset
//   instructions       : program image (NUM_INSTR x 32)
//   instrVld           : (re)start at pc 0, aborts any outstanding command
//   incPc              : outstanding command complete
//   begin_*, reg_wr_en : one-cycle strobes in the ISSUE cycle
//   reg_sel, reg_databus : register target and operand
//   pc                 : program counter
//   prog_done/prog_err : halted normally / on an illegal opcode
module instr_fetch_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_INSTR = 4096,
  localparam int unsigned PcW = $clog2(NUM_INSTR)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instructions [NUM_INSTR],
  input  logic            instrVld,
  input  logic            incPc,
  output logic            begin_rdn_load,
  output logic            begin_dnn_load,
  output logic            begin_proc,
  output logic [1:0]      reg_sel,
  output logic            reg_wr_en,
  output logic [27:0]     reg_databus,
  output logic [PcW-1:0]  pc,
  output logic            prog_done,
  output logic            prog_err
);

  localparam logic [PcW-1:0] PcLast = PcW'(NUM_INSTR - 1);

  ifd_state_t     state_q;
  logic [31:0]    ir_q;
  logic [PcW-1:0] pc_q;

  logic issue;
  logic is_cmd, is_halt, is_illegal;

  assign issue = (state_q == StIssue);

  instr_decoder u_decoder (
    .opcode         (ir_q[31:28]),
    .issue          (issue),
    .begin_rdn_load (begin_rdn_load),
    .begin_dnn_load (begin_dnn_load),
    .begin_proc     (begin_proc),
    .reg_wr_en      (reg_wr_en),
    .reg_sel        (reg_sel),
    .is_cmd         (is_cmd),
    .is_halt        (is_halt),
    .is_illegal     (is_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
    end else if (instrVld) begin
      // Restart wins over everything, including a coincident incPc.
      state_q <= StFetch;
      pc_q    <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          ir_q    <= instructions[pc_q];
          state_q <= StIssue;
        end
        StIssue: begin
          if (is_halt) begin
            state_q <= StHalted;
          end else if (is_illegal) begin
            state_q <= StError;
          end else if (is_cmd) begin
            state_q <= StWaitCtrl;
          end else if (pc_q == PcLast) begin
            // Completing the last word halts rather than wrapping.
            state_q <= StHalted;
          end else begin
            pc_q    <= pc_q + 1'b1;
            state_q <= StFetch;
          end
        end
        StWaitCtrl: begin
          if (incPc) begin
            if (pc_q == PcLast) begin
              state_q <= StHalted;
            end else begin
              pc_q    <= pc_q + 1'b1;
              state_q <= StFetch;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign reg_databus = issue ? ir_q[27:0] : 28'd0;
  assign pc          = pc_q;
  assign prog_done   = (state_q == StHalted);
  assign prog_err    = (state_q == StError);

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;
  import ctrl_pkg::*;

  localparam int unsigned N = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instrVld = 1'b0;
  logic        incPc = 1'b0;
  logic [31:0] prog [N];
  logic        begin_rdn_load, begin_dnn_load, begin_proc, reg_wr_en;
  logic [1:0]  reg_sel;
  logic [27:0] reg_databus;
  logic [11:0] pc;
  logic        prog_done, prog_err;
  logic [3:0]  strobes;

  instr_fetch_decode #(.NUM_INSTR(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instructions   (prog),
    .instrVld       (instrVld),
    .incPc          (incPc),
    .begin_rdn_load (begin_rdn_load),
    .begin_dnn_load (begin_dnn_load),
    .begin_proc     (begin_proc),
    .reg_sel        (reg_sel),
    .reg_wr_en      (reg_wr_en),
    .reg_databus    (reg_databus),
    .pc             (pc),
    .prog_done      (prog_done),
    .prog_err       (prog_err)
  );

  always #5 clk = ~clk;

  assign strobes = {begin_rdn_load, begin_dnn_load, begin_proc, reg_wr_en};

  // kind: 1 rdn, 2 dnn, 3 proc, 4 register write
  typedef struct packed {
    logic [2:0]  kind;
    logic [1:0]  sel;
    logic [27:0] data;
  } ev_t;

  ev_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] kind, input logic [1:0] sel, input logic [27:0] data);
    ev_t e;
    e.kind = kind;
    e.sel  = sel;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic pulse_vld();
    instrVld = 1'b1;
    tick(1);
    instrVld = 1'b0;
  endtask

  task automatic wait_dnn(input string tag);
    int k = 0;
    while (begin_dnn_load !== 1'b1 && k < 60) begin
      tick(1);
      k++;
    end
    check(tag, 40'(k < 60), 40'd1);
  endtask

  // Scoreboard: every strobe must match the next expected event; idle bus must be zero.
  ev_t obs_ev, exp_ev;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ($countones(strobes) > 1) begin
        check("one_hot", 40'($countones(strobes)), 40'd1);
      end else if (strobes != 4'd0) begin
        obs_ev.kind = begin_rdn_load ? 3'd1 : begin_dnn_load ? 3'd2 : begin_proc ? 3'd3 : 3'd4;
        obs_ev.sel  = reg_sel;
        obs_ev.data = reg_databus;
        if (sb.size() == 0) begin
          check("unexpected_strobe", 40'(obs_ev), 40'd0);
        end else begin
          exp_ev = sb.pop_front();
          check("sb_event", 40'(obs_ev), 40'(exp_ev));
        end
      end else begin
        check("idle_bus", 40'({reg_sel, reg_databus}), 40'd0);
      end
    end
  end

  initial begin
    logic [3:0] seen;
    int k;
    logic left_zero, wrapped;

    for (int i = 0; i < N; i++) prog[i] = 32'h0;

    // Reset state
    #1;
    check("reset_outputs", 40'({strobes, reg_sel, reg_databus, pc, prog_done, prog_err}), 40'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("idle_after_reset", 40'({strobes, pc, prog_done, prog_err}), 40'd0);

    // Register writes then HALT
    prog[0] = 32'h4000_0100;
    prog[1] = 32'h5000_0002;
    prog[2] = 32'h6000_0200;
    prog[3] = 32'h0000_0000;
    push(3'd4, 2'b00, 28'h100);
    push(3'd4, 2'b01, 28'h2);
    push(3'd4, 2'b10, 28'h200);
    pulse_vld();
    check("fetch_no_strobe", 40'(strobes), 40'd0);
    tick(1);
    check("wr0_timing", 40'({reg_wr_en, reg_sel}), 40'({1'b1, 2'b00}));
    tick(2);
    check("wr1_timing", 40'({reg_wr_en, reg_sel}), 40'({1'b1, 2'b01}));
    tick(2);
    check("wr2_timing", 40'({reg_wr_en, reg_sel}), 40'({1'b1, 2'b10}));
    tick(2);
    check("halt_issue_not_done", 40'(prog_done), 40'd0);
    tick(1);
    check("halt_done_pc", 40'({prog_done, prog_err, pc}), 40'({1'b1, 1'b0, 12'd3}));

    // Command stall on LOAD_RDN
    prog[0] = 32'h1000_0040;
    prog[1] = 32'h0000_0000;
    push(3'd1, 2'b00, 28'h40);
    pulse_vld();
    tick(1);
    check("rdn_strobe", 40'({begin_rdn_load, reg_databus}), 40'({1'b1, 28'h40}));
    seen = 4'd0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen |= strobes;
    end
    check("stall_quiet", 40'({seen, prog_done, pc}), 40'd0);
    incPc = 1'b1;
    tick(1);
    incPc = 1'b0;
    tick(2);
    check("rdn_then_halt", 40'({prog_done, pc}), 40'({1'b1, 12'd1}));

    // incPc during ISSUE ignored, then illegal opcode
    prog[0] = 32'h3000_0000;
    prog[1] = 32'h9000_0000;
    push(3'd3, 2'b00, 28'h0);
    pulse_vld();
    tick(1);
    check("proc_strobe", 40'(begin_proc), 40'd1);
    incPc = 1'b1;
    tick(1);
    incPc = 1'b0;
    tick(3);
    check("issue_incpc_ignored", 40'({pc, prog_err, prog_done, strobes}), 40'd0);
    incPc = 1'b1;
    tick(1);
    incPc = 1'b0;
    check("incpc_advances", 40'(pc), 40'd1);
    tick(1);
    check("illegal_no_strobe", 40'(strobes), 40'd0);
    tick(1);
    check("illegal_err", 40'({prog_err, prog_done, pc}), 40'({1'b1, 1'b0, 12'd1}));

    // Abort from WAIT_CTRL at pc 5 with coincident incPc, then async reset mid-wait
    prog[0] = 32'h4000_0011;
    for (int i = 1; i < 5; i++) prog[i] = 32'h7000_0000;
    prog[5] = 32'h2000_0055;
    push(3'd4, 2'b00, 28'h11);
    push(3'd2, 2'b00, 28'h55);
    pulse_vld();
    tick(1);
    check("abort_first_wr", 40'(reg_wr_en), 40'd1);
    wait_dnn("dnn_timeout_1");
    check("dnn_pc", 40'(pc), 40'd5);
    tick(1);
    push(3'd4, 2'b00, 28'h11);
    instrVld = 1'b1;
    incPc    = 1'b1;
    tick(1);
    instrVld = 1'b0;
    incPc    = 1'b0;
    check("abort_pc", 40'({pc, strobes}), 40'd0);
    tick(1);
    check("reissue_pc0", 40'({reg_wr_en, pc}), 40'({1'b1, 12'd0}));
    push(3'd2, 2'b00, 28'h55);
    wait_dnn("dnn_timeout_2");
    tick(1);
    rst_n = 1'b0;
    #1;
    check("async_reset", 40'({strobes, reg_sel, reg_databus, pc, prog_done, prog_err}), 40'd0);
    tick(1);
    rst_n = 1'b1;
    incPc = 1'b1;
    tick(1);
    incPc = 1'b0;
    tick(3);
    check("post_reset_idle", 40'({strobes, pc, prog_done, prog_err}), 40'd0);

    // 4096 NOPs: halt at the last word, no wrap
    for (int i = 0; i < N; i++) prog[i] = 32'h7000_0000;
    pulse_vld();
    k = 0;
    left_zero = 1'b0;
    wrapped   = 1'b0;
    while (prog_done !== 1'b1 && k < 9000) begin
      tick(1);
      k++;
      if (pc != 12'd0) left_zero = 1'b1;
      else if (left_zero) wrapped = 1'b1;
    end
    check("nop_done_timeout", 40'(k < 9000), 40'd1);
    check("nop_no_wrap", 40'(wrapped), 40'd0);
    tick(3);
    check("nop_end_pc", 40'({prog_done, prog_err, pc}), 40'({1'b1, 1'b0, 12'd4095}));

    check("sb_empty", 40'(sb.size()), 40'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
